// File: rtl/uni_pkg.sv
// Shared constants and types for the uni bus arbiter.
package uni_pkg;

   localparam logic [1:0] UNI_SZ_B = 2'b00;
   localparam logic [1:0] UNI_SZ_H = 2'b01;
   localparam logic [1:0] UNI_SZ_W = 2'b10;
   localparam logic [1:0] UNI_SZ_D = 2'b11;

   localparam logic UNI_RD = 1'b0;
   localparam logic UNI_WR = 1'b1;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

endpackage

// File: rtl/uni_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module uni_rr_pick import uni_pkg::*; #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] req_msk;
   logic           found;

   // Upper copy is never masked, so a request below the pointer is still found there.
   always_comb begin
      req_dbl = {i_req, i_req};
      for (int i = 0; i < 2 * N; i++) begin
         req_msk[i] = req_dbl[i] && (i >= int'(i_ptr));
      end
      o_gnt = '0;
      o_idx = '0;
      found = 1'b0;
      for (int i = 0; i < 2 * N; i++) begin
         if (!found && req_msk[i]) begin
            found            = 1'b1;
            o_idx            = IW'(i % N);
            o_gnt[i % N]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uni_arb_n.sv
// N-to-1 uni bus arbiter: one transaction in flight, fixed-priority or round-robin grants.
module uni_arb_n import uni_pkg::*; #(
   parameter int unsigned N_MST  = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned RR_EN  = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [N_MST-1:0]           m_valid,
   output logic [N_MST-1:0]           m_ready,
   input  logic [N_MST-1:0]           m_reqtyp,
   input  logic [N_MST*ADDR_W-1:0]    m_addr,
   input  logic [N_MST*DATA_W-1:0]    m_wdata,
   output logic [DATA_W-1:0]          m_rdata,
   input  logic [N_MST-1:0]           m_cachable,
   input  logic [N_MST*2-1:0]         m_size,
   output logic                       s_valid,
   output logic                       s_reqtyp,
   output logic [ADDR_W-1:0]          s_addr,
   output logic [DATA_W-1:0]          s_wdata,
   output logic                       s_cachable,
   output logic [1:0]                 s_size,
   input  logic                       s_ready,
   input  logic [DATA_W-1:0]          s_rdata,
   output logic [$clog2(N_MST)-1:0]   o_grant,
   output logic                       o_busy,
   output logic                       o_err
);

   localparam int unsigned IW = $clog2(N_MST);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic            err_q, err_d;

   logic [IW-1:0]    pick_ptr;
   logic [IW-1:0]    pick_idx;
   logic [N_MST-1:0] pick_gnt;
   int               sel;

   // A zero pointer turns the round-robin search into plain lowest-index priority.
   assign pick_ptr = (RR_EN != 0) ? rr_q : '0;

   uni_rr_pick #(
      .N  (N_MST),
      .IW (IW)
   ) u_pick (
      .i_req (m_valid),
      .i_ptr (pick_ptr),
      .o_gnt (pick_gnt),
      .o_idx (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      err_d      = err_q;
      sel        = int'(grant_q);
      m_ready    = '0;
      s_valid    = 1'b0;
      s_reqtyp   = 1'b0;
      s_addr     = '0;
      s_wdata    = '0;
      s_cachable = 1'b0;
      s_size     = 2'b00;
      unique case (state_q)
         ARB_IDLE: begin
            if (s_ready) begin
               err_d = 1'b1;
            end
            if (|pick_gnt) begin
               grant_d = pick_idx;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            s_valid      = m_valid[sel];
            s_reqtyp     = m_reqtyp[sel];
            s_addr       = m_addr[sel*ADDR_W +: ADDR_W];
            s_wdata      = m_wdata[sel*DATA_W +: DATA_W];
            s_cachable   = m_cachable[sel];
            s_size       = m_size[sel*2 +: 2];
            m_ready[sel] = s_ready;
            // A dropped request is flagged but the transaction is never aborted.
            if (!m_valid[sel]) begin
               err_d = 1'b1;
            end
            if (s_ready) begin
               state_d = ARB_IDLE;
               if (RR_EN != 0) begin
                  rr_d = (sel == int'(N_MST) - 1) ? '0 : grant_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         err_q   <= err_d;
      end
   end

   assign m_rdata = s_rdata;
   assign o_grant = grant_q;
   assign o_busy  = (state_q == ARB_BUSY);
   assign o_err   = err_q;

endmodule

// File: tb/tb_uni_arb_n.sv
// Bench for uni_arb_n: directed scenarios plus random traffic against a transaction-level model.
module tb_uni_arb_n;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = $clog2(N);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    m_valid, m_ready, m_reqtyp, m_cachable;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [N*2-1:0]  m_size;
   logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
   logic            s_valid, s_reqtyp, s_cachable, s_ready;
   logic [AW-1:0]   s_addr;
   logic [1:0]      s_size;
   logic [IW-1:0]   o_grant;
   logic            o_busy, o_err;

   logic            fp_rst;
   logic [N-1:0]    fp_m_valid, fp_m_ready, fp_m_reqtyp, fp_m_cachable;
   logic [N*AW-1:0] fp_m_addr;
   logic [N*DW-1:0] fp_m_wdata;
   logic [N*2-1:0]  fp_m_size;
   logic [DW-1:0]   fp_m_rdata, fp_s_wdata, fp_s_rdata;
   logic            fp_s_valid, fp_s_reqtyp, fp_s_cachable, fp_s_ready;
   logic [AW-1:0]   fp_s_addr;
   logic [1:0]      fp_s_size;
   logic [IW-1:0]   fp_o_grant;
   logic            fp_o_busy, fp_o_err;

   uni_arb_n #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) u_dut (
      .i_clk(clk), .i_rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_reqtyp(m_reqtyp),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_cachable(m_cachable),
      .m_size(m_size), .s_valid(s_valid), .s_reqtyp(s_reqtyp), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_cachable(s_cachable), .s_size(s_size), .s_ready(s_ready),
      .s_rdata(s_rdata), .o_grant(o_grant), .o_busy(o_busy), .o_err(o_err)
   );

   uni_arb_n #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) u_fp (
      .i_clk(clk), .i_rst(fp_rst), .m_valid(fp_m_valid), .m_ready(fp_m_ready),
      .m_reqtyp(fp_m_reqtyp), .m_addr(fp_m_addr), .m_wdata(fp_m_wdata), .m_rdata(fp_m_rdata),
      .m_cachable(fp_m_cachable), .m_size(fp_m_size), .s_valid(fp_s_valid),
      .s_reqtyp(fp_s_reqtyp), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
      .s_cachable(fp_s_cachable), .s_size(fp_s_size), .s_ready(fp_s_ready),
      .s_rdata(fp_s_rdata), .o_grant(fp_o_grant), .o_busy(fp_o_busy), .o_err(fp_o_err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: which master owns the bus, where the rotation starts, sticky error.
   bit           mdl_busy;
   bit           mdl_err;
   int           mdl_grant;
   int           mdl_ptr;
   logic [N-1:0] ack;

   function automatic int winner(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   // Compare outputs mid-cycle against the model, advance the model, move to the next cycle.
   task automatic tick();
      logic [N-1:0] exp_ready;
      int g;
      @(negedge clk);
      exp_ready = '0;
      g = mdl_grant;
      if (mdl_busy) begin
         check_eq("s_valid", 64'(s_valid), 64'(m_valid[g]));
         check_eq("s_reqtyp", 64'(s_reqtyp), 64'(m_reqtyp[g]));
         check_eq("s_addr", 64'(s_addr), 64'(m_addr[g*AW +: AW]));
         check_eq("s_wdata", s_wdata, m_wdata[g*DW +: DW]);
         check_eq("s_cachable", 64'(s_cachable), 64'(m_cachable[g]));
         check_eq("s_size", 64'(s_size), 64'(m_size[g*2 +: 2]));
         exp_ready[g] = s_ready;
      end else begin
         check_eq("idle_s_valid", 64'(s_valid), 64'(0));
         check_eq("idle_s_fields", 64'({s_reqtyp, s_cachable, s_size}), 64'(0));
         check_eq("idle_s_addr", 64'(s_addr), 64'(0));
         check_eq("idle_s_wdata", s_wdata, 64'(0));
      end
      check_eq("m_ready", 64'(m_ready), 64'(exp_ready));
      check_eq("m_rdata", m_rdata, s_rdata);
      check_eq("o_busy", 64'(o_busy), 64'(mdl_busy));
      check_eq("o_grant", 64'(o_grant), 64'(mdl_grant));
      check_eq("o_err", 64'(o_err), 64'(mdl_err));
      ack = exp_ready;
      if (rst) begin
         mdl_busy = 0; mdl_err = 0; mdl_grant = 0; mdl_ptr = 0;
      end else if (!mdl_busy) begin
         if (s_ready) mdl_err = 1;
         if (|m_valid) begin
            mdl_grant = winner(m_valid, mdl_ptr);
            mdl_busy  = 1;
         end
      end else begin
         if (!m_valid[g]) mdl_err = 1;
         if (s_ready) begin
            mdl_busy = 0;
            mdl_ptr  = (g + 1) % N;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic typ, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic cach, input logic [1:0] sz);
      m_valid[i]          = 1'b1;
      m_reqtyp[i]         = typ;
      m_addr[i*AW +: AW]  = a;
      m_wdata[i*DW +: DW] = wd;
      m_cachable[i]       = cach;
      m_size[i*2 +: 2]    = sz;
   endtask

   task automatic rand_req(input int i);
      set_req(i, 1'($urandom), $urandom, {$urandom, $urandom}, 1'($urandom), 2'($urandom));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int exp_order [5] = '{0, 1, 2, 3, 0};
   int n;

   initial begin
      rst = 1'b1; m_valid = '0; m_reqtyp = '0; m_cachable = '0; m_addr = '0; m_wdata = '0;
      m_size = '0; s_ready = 1'b0; s_rdata = '0; ack = '0;
      fp_rst = 1'b1; fp_m_valid = '0; fp_m_reqtyp = '0; fp_m_cachable = '1;
      fp_m_addr = {32'h4000_0030, 32'h3000_0020, 32'h2000_0010, 32'h1000_0000};
      fp_m_wdata = '0; fp_m_size = '1; fp_s_ready = 1'b0; fp_s_rdata = 64'h1234;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      mdl_busy = 0; mdl_err = 0; mdl_grant = 0; mdl_ptr = 0;
      check_eq("rst_busy", 64'(o_busy), 64'(0));
      check_eq("rst_err", 64'(o_err), 64'(0));
      check_eq("rst_svalid", 64'(s_valid), 64'(0));
      tick();

      // Single master read, slave answers three cycles after s_valid.
      set_req(1, 1'b0, 32'h8000_0010, '0, 1'b1, 2'b11);
      tick();
      check_eq("t1_saddr", 64'(s_addr), 64'h8000_0010);
      check_eq("t1_svalid", 64'(s_valid), 64'(1));
      tick(); tick(); tick();
      s_ready = 1'b1; s_rdata = 64'hDEAD_BEEF_0123_4567;
      #1;
      check_eq("t1_mready", 64'(m_ready), 64'b0010);
      check_eq("t1_rdata", m_rdata, 64'hDEAD_BEEF_0123_4567);
      tick();
      s_ready = 1'b0; m_valid = '0;
      #1;
      check_eq("t1_done", 64'(o_busy), 64'(0));
      tick();

      // Round-robin contention with every master requesting.
      do_reset();
      for (int i = 0; i < N; i++) rand_req(i);
      for (int tx = 0; tx < 5; tx++) begin
         tick();
         #1;
         check_eq("rr_grant", 64'(o_grant), 64'(exp_order[tx]));
         tick();
         s_ready = 1'b1;
         #1;
         check_eq("rr_mready", 64'(m_ready), 64'(1) << exp_order[tx]);
         tick();
         s_ready = 1'b0;
         rand_req(exp_order[tx]);
      end
      m_valid = '0;
      tick();

      // Write pass-through.
      set_req(1, 1'b1, 32'h0000_1000, 64'h55, 1'b0, 2'b00);
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         check_eq("wr_reqtyp", 64'(s_reqtyp), 64'(1));
         check_eq("wr_wdata", s_wdata, 64'h55);
         check_eq("wr_size", 64'(s_size), 64'(0));
         check_eq("wr_cach", 64'(s_cachable), 64'(0));
         tick();
      end
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0; m_valid = '0;
      tick();

      // Stray slave strobe in IDLE.
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0;
      #1;
      check_eq("err_idle", 64'(o_err), 64'(1));
      tick(); tick();
      check_eq("err_sticky", 64'(o_err), 64'(1));
      do_reset();

      // Master drops valid while BUSY.
      set_req(0, 1'b0, 32'h0000_2000, '0, 1'b1, 2'b10);
      tick(); tick();
      m_valid[0] = 1'b0;
      tick();
      #1;
      check_eq("drop_err", 64'(o_err), 64'(1));
      check_eq("drop_busy", 64'(o_busy), 64'(1));
      tick();
      check_eq("drop_still_busy", 64'(o_busy), 64'(1));
      m_valid[0] = 1'b1; s_ready = 1'b1;
      tick();
      s_ready = 1'b0; m_valid = '0;
      tick();

      // Reset in the middle of a transaction to master 2.
      set_req(2, 1'b0, 32'h0000_3000, '0, 1'b0, 2'b01);
      tick(); tick();
      check_eq("mid_grant", 64'(o_grant), 64'(2));
      do_reset();
      #1;
      check_eq("mid_svalid", 64'(s_valid), 64'(0));
      check_eq("mid_busy", 64'(o_busy), 64'(0));
      check_eq("mid_err", 64'(o_err), 64'(0));
      for (int i = 0; i < N; i++) rand_req(i);
      tick();
      #1;
      check_eq("mid_regrant", 64'(o_grant), 64'(0));
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0; m_valid = '0;
      tick();

      // Random traffic with protocol-respecting masters and slave.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (m_valid[i]) begin
               if (ack[i]) begin
                  if ($urandom_range(0, 1) == 0) rand_req(i);
                  else m_valid[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               rand_req(i);
            end
         end
         s_ready = mdl_busy && m_valid[mdl_grant] && ($urandom_range(0, 2) == 0);
         s_rdata = {$urandom, $urandom};
         tick();
      end
      s_ready = 1'b0; m_valid = '0;

      // Fixed priority: masters 0 and 2 requesting continuously.
      fp_rst = 1'b0;
      fp_m_valid = 4'b0101;
      for (int tx = 0; tx < 4; tx++) begin
         n = 0;
         while (!fp_o_busy && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         check_eq("fp_wait", 64'(n < 10), 64'(1));
         check_eq("fp_grant", 64'(fp_o_grant), 64'(0));
         check_eq("fp_saddr", 64'(fp_s_addr), 64'h1000_0000);
         fp_s_ready = 1'b1;
         #1;
         check_eq("fp_mready", 64'(fp_m_ready), 64'b0001);
         check_eq("fp_rdata", fp_m_rdata, 64'h1234);
         @(posedge clk); #1;
         fp_s_ready = 1'b0;
         check_eq("fp_idle", 64'(fp_o_busy), 64'(0));
      end
      fp_m_valid = 4'b0100;
      n = 0;
      while (!fp_o_busy && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("fp_wait2", 64'(n < 10), 64'(1));
      check_eq("fp_grant2", 64'(fp_o_grant), 64'(2));
      check_eq("fp_err", 64'(fp_o_err), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
